// File: rtl/proc_mem_pkg.sv
// Shared definitions for the TinyRV1 memory responder:
// MMIO offsets, request types and the common address decoder.
package proc_mem_pkg;

    // Byte offsets from the MMIO base
    localparam logic [31:0] MMIO_OUT0 = 32'h0000_0000;
    localparam logic [31:0] MMIO_OUT1 = 32'h0000_0004;
    localparam logic [31:0] MMIO_OUT2 = 32'h0000_0008;
    localparam logic [31:0] MMIO_IN0  = 32'h0000_0010;
    localparam logic [31:0] MMIO_IN1  = 32'h0000_0014;
    localparam logic [31:0] MMIO_IN2  = 32'h0000_0018;

    // Data request type
    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_MMIO_OUT,
        DEC_MMIO_IN,
        DEC_MISALIGN,
        DEC_OOB
    } dec_e;

    // Misalignment wins over every other class, and RAM wins over
    // MMIO should the two ranges ever overlap.
    function automatic dec_e mem_decode(
        input logic [31:0] addr,
        input logic [31:0] ram_bytes,
        input logic [31:0] base
    );
        dec_e d;
        if (addr[1:0] != 2'b00) begin
            d = DEC_MISALIGN;
        end else if (addr < ram_bytes) begin
            d = DEC_RAM;
        end else if (addr == base + MMIO_OUT0 ||
                     addr == base + MMIO_OUT1 ||
                     addr == base + MMIO_OUT2) begin
            d = DEC_MMIO_OUT;
        end else if (addr == base + MMIO_IN0 ||
                     addr == base + MMIO_IN1 ||
                     addr == base + MMIO_IN2) begin
            d = DEC_MMIO_IN;
        end else begin
            d = DEC_OOB;
        end
        return d;
    endfunction

    // Slot 0/1/2 within the out or in group of the MMIO window
    function automatic logic [1:0] mmio_slot(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [1:0] s;
        if (addr == base + MMIO_OUT1 || addr == base + MMIO_IN1) begin
            s = 2'd1;
        end else if (addr == base + MMIO_OUT2 ||
                     addr == base + MMIO_IN2) begin
            s = 2'd2;
        end else begin
            s = 2'd0;
        end
        return s;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
// Synchronous active-low clear has priority over enable.
module sat_counter16 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    output logic [15:0] count
);

    // Clear, otherwise count up until saturated
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= 16'h0000;
        end else if (en && count != 16'hFFFF) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/proc_mem_responder.sv
// Target side of the TinyRV1 imem/dmem interface: word RAM,
// board MMIO, sticky error capture and access statistics.
module proc_mem_responder
    import proc_mem_pkg::*;
#(
    parameter int          NUM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,

    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,

    input  logic        load_val,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,

    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,

    output logic        err_misaligned,
    output logic        err_oob,
    output logic [31:0] err_addr,
    output logic [15:0] num_loads,
    output logic [15:0] num_stores
);

    localparam int          AW        = $clog2(NUM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(NUM_WORDS * 4);

    logic [31:0] mem [NUM_WORDS];

    dec_e       i_dec;
    dec_e       d_dec;
    dec_e       p_dec;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic [AW-1:0] p_idx;
    logic [1:0] d_slot;

    logic       d_load;
    logic       d_store;
    logic       p_ram;
    logic       collide;
    logic       ld_ok;
    logic       st_ram;
    logic       st_out;
    logic       st_ok;
    logic       d_mis;
    logic       d_oob;
    logic       i_mis;
    logic       i_oob;
    logic       d_err;
    logic       i_err;

    logic [31:0] out0_q;
    logic [31:0] out1_q;
    logic [31:0] out2_q;
    logic        mis_q;
    logic        oob_q;
    logic        seen_q;
    logic [31:0] eaddr_q;

    assign i_dec  = mem_decode(imemreq_addr, RAM_BYTES, MMIO_BASE);
    assign d_dec  = mem_decode(dmemreq_addr, RAM_BYTES, MMIO_BASE);
    assign p_dec  = mem_decode(load_addr, RAM_BYTES, MMIO_BASE);
    assign i_idx  = imemreq_addr[AW+1:2];
    assign d_idx  = dmemreq_addr[AW+1:2];
    assign p_idx  = load_addr[AW+1:2];
    assign d_slot = mmio_slot(dmemreq_addr, MMIO_BASE);

    assign d_load  = dmemreq_val && (dmemreq_type == MEM_LOAD);
    assign d_store = dmemreq_val && (dmemreq_type == MEM_STORE);

    // A preload to the same word silently pre-empts a store
    assign p_ram   = load_val && (p_dec == DEC_RAM);
    assign collide = p_ram && d_store && (d_dec == DEC_RAM)
                     && (p_idx == d_idx);

    assign ld_ok  = d_load && (d_dec == DEC_RAM ||
                               d_dec == DEC_MMIO_OUT ||
                               d_dec == DEC_MMIO_IN);
    assign st_ram = d_store && (d_dec == DEC_RAM) && !collide;
    assign st_out = d_store && (d_dec == DEC_MMIO_OUT);
    assign st_ok  = st_ram || st_out;

    // Input registers are read-only, so storing to them is out of bounds
    assign d_mis = dmemreq_val && (d_dec == DEC_MISALIGN);
    assign d_oob = dmemreq_val && ((d_dec == DEC_OOB) ||
                   (d_store && d_dec == DEC_MMIO_IN));
    assign i_mis = imemreq_val && (i_dec == DEC_MISALIGN);
    assign i_oob = imemreq_val && (i_dec == DEC_OOB ||
                                   i_dec == DEC_MMIO_OUT ||
                                   i_dec == DEC_MMIO_IN);
    assign d_err = d_mis || d_oob;
    assign i_err = i_mis || i_oob;

    // Instruction fetch: RAM only, zero otherwise
    always_comb begin
        imemresp_data = 32'h0;
        if (imemreq_val && i_dec == DEC_RAM) begin
            imemresp_data = mem[i_idx];
        end
    end

    // Data load mux across RAM and the MMIO window
    always_comb begin
        dmemresp_rdata = 32'h0;
        if (d_load) begin
            unique case (d_dec)
                DEC_RAM: begin
                    dmemresp_rdata = mem[d_idx];
                end
                DEC_MMIO_OUT: begin
                    unique case (d_slot)
                        2'd1:    dmemresp_rdata = out1_q;
                        2'd2:    dmemresp_rdata = out2_q;
                        default: dmemresp_rdata = out0_q;
                    endcase
                end
                DEC_MMIO_IN: begin
                    unique case (d_slot)
                        2'd1:    dmemresp_rdata = in1;
                        2'd2:    dmemresp_rdata = in2;
                        default: dmemresp_rdata = in0;
                    endcase
                end
                default: dmemresp_rdata = 32'h0;
            endcase
        end
    end

    // RAM writes: preload ignores reset, stores are gated by it
    always_ff @(posedge clk) begin
        if (p_ram) begin
            mem[p_idx] <= load_data;
        end
        if (rst && st_ram) begin
            mem[d_idx] <= dmemreq_wdata;
        end
    end

    // Board output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            out0_q <= 32'h0;
            out1_q <= 32'h0;
            out2_q <= 32'h0;
        end else if (st_out) begin
            unique case (d_slot)
                2'd1:    out1_q <= dmemreq_wdata;
                2'd2:    out2_q <= dmemreq_wdata;
                default: out0_q <= dmemreq_wdata;
            endcase
        end
    end

    // Sticky error flags and first-error address capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            mis_q   <= 1'b0;
            oob_q   <= 1'b0;
            seen_q  <= 1'b0;
            eaddr_q <= 32'h0;
        end else begin
            if (d_mis || i_mis) begin
                mis_q <= 1'b1;
            end
            if (d_oob || i_oob) begin
                oob_q <= 1'b1;
            end
            if (!seen_q && (d_err || i_err)) begin
                seen_q  <= 1'b1;
                eaddr_q <= d_err ? dmemreq_addr : imemreq_addr;
            end
        end
    end

    sat_counter16 u_load_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (ld_ok),
        .count (num_loads)
    );

    sat_counter16 u_store_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (st_ok),
        .count (num_stores)
    );

    assign out0           = out0_q;
    assign out1           = out1_q;
    assign out2           = out2_q;
    assign err_misaligned = mis_q;
    assign err_oob        = oob_q;
    assign err_addr       = eaddr_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder: directed plan,
// vector table, randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_proc_mem_responder;

    localparam int          NW   = 256;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic [31:0] dmemresp_rdata;
    logic        load_val;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] in0, in1, in2;
    logic [31:0] out0, out1, out2;
    logic        err_misaligned;
    logic        err_oob;
    logic [31:0] err_addr;
    logic [15:0] num_loads;
    logic [15:0] num_stores;

    always #5 clk = ~clk;

    proc_mem_responder #(
        .NUM_WORDS (NW),
        .MMIO_BASE (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_addr   (imemreq_addr),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_rdata (dmemresp_rdata),
        .load_val       (load_val),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .in0            (in0),
        .in1            (in1),
        .in2            (in2),
        .out0           (out0),
        .out1           (out1),
        .out2           (out2),
        .err_misaligned (err_misaligned),
        .err_oob        (err_oob),
        .err_addr       (err_addr),
        .num_loads      (num_loads),
        .num_stores     (num_stores)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_mem [NW];
    logic [31:0] m_out [3];
    bit          m_mis, m_oob, m_seen;
    logic [31:0] m_eaddr;
    int          m_nl, m_ns;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic bit f_ram(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(NW * 4));
    endfunction

    function automatic bit f_out(input logic [31:0] a);
        return !f_ram(a) && (a % 4 == 0) && (a >= BASE)
               && (a - BASE <= 32'd8);
    endfunction

    function automatic bit f_in(input logic [31:0] a);
        return !f_ram(a) && (a % 4 == 0) && (a >= BASE + 32'd16)
               && (a - BASE <= 32'd24);
    endfunction

    function automatic logic [31:0] in_word(input int k);
        return (k == 0) ? in0 : (k == 1) ? in1 : in2;
    endfunction

    function automatic logic [31:0] exp_fetch();
        if (imemreq_val && f_ram(imemreq_addr))
            return m_mem[int'(imemreq_addr >> 2)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_load();
        logic [31:0] a;
        a = dmemreq_addr;
        if (!dmemreq_val || dmemreq_type) return 32'h0;
        if (f_ram(a)) return m_mem[int'(a >> 2)];
        if (f_out(a)) return m_out[int'((a - BASE) >> 2)];
        if (f_in(a))  return in_word(int'((a - BASE) >> 2) - 4);
        return 32'h0;
    endfunction

    // Advance the model across one clock edge using current inputs
    task automatic model_edge();
        bit pre, coll, dm, dob, im, iob;
        logic [31:0] a;
        a    = dmemreq_addr;
        pre  = load_val && f_ram(load_addr);
        coll = pre && dmemreq_val && dmemreq_type && f_ram(a)
               && ((a >> 2) == (load_addr >> 2));
        if (!rst) begin
            m_out   = '{32'h0, 32'h0, 32'h0};
            m_mis   = 0;
            m_oob   = 0;
            m_seen  = 0;
            m_eaddr = 32'h0;
            m_nl    = 0;
            m_ns    = 0;
        end else begin
            dm  = 0;
            dob = 0;
            if (dmemreq_val) begin
                if (a % 4 != 0) begin
                    dm = 1;
                end else if (!dmemreq_type) begin
                    if (f_ram(a) || f_out(a) || f_in(a)) begin
                        if (m_nl < 65535) m_nl++;
                    end else begin
                        dob = 1;
                    end
                end else if (f_ram(a)) begin
                    if (!coll) begin
                        m_mem[int'(a >> 2)] = dmemreq_wdata;
                        if (m_ns < 65535) m_ns++;
                    end
                end else if (f_out(a)) begin
                    m_out[int'((a - BASE) >> 2)] = dmemreq_wdata;
                    if (m_ns < 65535) m_ns++;
                end else begin
                    dob = 1;
                end
            end
            im  = imemreq_val && (imemreq_addr % 4 != 0);
            iob = imemreq_val && !im && !f_ram(imemreq_addr);
            if (dm || im) m_mis = 1;
            if (dob || iob) m_oob = 1;
            if (!m_seen && (dm || dob || im || iob)) begin
                m_seen  = 1;
                m_eaddr = (dm || dob) ? a : imemreq_addr;
            end
        end
        if (pre) m_mem[int'(load_addr >> 2)] = load_data;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imemreq_val   = 0;
        imemreq_addr  = 0;
        dmemreq_val   = 0;
        dmemreq_type  = 0;
        dmemreq_addr  = 0;
        dmemreq_wdata = 0;
        load_val      = 0;
        load_addr     = 0;
        load_data     = 0;
    endtask

    task automatic dreq(input logic t, input logic [31:0] a,
                        input logic [31:0] w);
        dmemreq_val   = 1;
        dmemreq_type  = t;
        dmemreq_addr  = a;
        dmemreq_wdata = w;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".out0"}, out0, m_out[0]);
        chk({tag, ".out1"}, out1, m_out[1]);
        chk({tag, ".out2"}, out2, m_out[2]);
        chk({tag, ".mis"}, 32'(err_misaligned), 32'(m_mis));
        chk({tag, ".oob"}, 32'(err_oob), 32'(m_oob));
        chk({tag, ".eaddr"}, err_addr, m_eaddr);
        chk({tag, ".nl"}, 32'(num_loads), 32'(m_nl));
        chk({tag, ".ns"}, 32'(num_stores), 32'(m_ns));
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 32'($urandom_range(0, NW - 1)) << 2;
            4: return (32'($urandom_range(0, NW - 1)) << 2)
                      | 32'($urandom_range(1, 3));
            5: return BASE + 32'($urandom_range(0, 2)) * 4;
            6: return BASE + 32'h10 + 32'($urandom_range(0, 2)) * 4;
            7: return BASE + ($urandom_range(0, 1) ? 32'h0C : 32'h1C);
            8: return 32'(NW * 4) + 32'($urandom_range(0, 3)) * 4;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic        r;
        logic        v;
        logic        t;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] rd;
        logic        mis;
        logic        oob;
        logic [31:0] ea;
        int          nl;
        int          ns;
        logic [31:0] o2;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{0, 0, 0, 32'h0,    32'h0,    32'h0,        0, 0, 32'h0,    0, 0, 32'h0};
        tbl[1]  = '{1, 1, 0, 32'h2014, 32'h0,    32'hA5A5A5A5, 0, 0, 32'h0,    1, 0, 32'h0};
        tbl[2]  = '{1, 1, 1, 32'h2008, 32'h7,    32'h0,        0, 0, 32'h0,    1, 1, 32'h7};
        tbl[3]  = '{1, 1, 0, 32'h2008, 32'h0,    32'h7,        0, 0, 32'h0,    2, 1, 32'h7};
        tbl[4]  = '{1, 1, 0, 32'h2010, 32'h0,    32'h11111111, 0, 0, 32'h0,    3, 1, 32'h7};
        tbl[5]  = '{1, 1, 0, 32'h0004, 32'h0,    32'hDEADBEEF, 0, 0, 32'h0,    4, 1, 32'h7};
        tbl[6]  = '{1, 1, 0, 32'h0040, 32'h0,    32'h12345678, 0, 0, 32'h0,    5, 1, 32'h7};
        tbl[7]  = '{1, 1, 1, 32'h2010, 32'h99,   32'h0,        0, 1, 32'h2010, 5, 1, 32'h7};
        tbl[8]  = '{1, 1, 0, 32'h0042, 32'h0,    32'h0,        1, 1, 32'h2010, 5, 1, 32'h7};
        tbl[9]  = '{0, 1, 1, 32'h2000, 32'hFFFF, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0};
        tbl[10] = '{1, 1, 0, 32'h0042, 32'h0,    32'h0,        1, 0, 32'h42,   0, 0, 32'h0};
        tbl[11] = '{1, 1, 1, 32'h8000, 32'hBAD,  32'h0,        1, 1, 32'h42,   0, 0, 32'h0};
        tbl[12] = '{1, 1, 0, 32'h0000, 32'h0,    32'h00500093, 1, 1, 32'h42,   1, 0, 32'h0};
        tbl[13] = '{1, 1, 0, 32'h2000, 32'h0,    32'h0,        1, 1, 32'h42,   2, 0, 32'h0};
        tbl[14] = '{1, 1, 0, 32'h201C, 32'h0,    32'h0,        1, 1, 32'h42,   2, 0, 32'h0};
        tbl[15] = '{1, 1, 0, 32'h0400, 32'h0,    32'h0,        1, 1, 32'h42,   2, 0, 32'h0};
    end

    initial begin
        idle();
        rst = 0;
        in0 = 32'h11111111;
        in1 = 32'hA5A5A5A5;
        in2 = 32'h22222222;
        @(posedge clk);
        #1;
        tick();
        chk("rst.out0", out0, 32'h0);
        chk("rst.flags", {30'h0, err_misaligned, err_oob}, 32'h0);
        chk("rst.cnt", {num_loads, num_stores}, 32'h0);

        // Preload every word under reset, then the boot words
        for (int i = 0; i < NW; i++) begin
            load_val  = 1;
            load_addr = 32'(i) << 2;
            load_data = {16'hC0DE, 16'(i)};
            tick();
        end
        load_addr = 32'h0; load_data = 32'h00500093; tick();
        load_addr = 32'h4; load_data = 32'hDEADBEEF; tick();
        idle();
        rst = 1;

        // Fetch after release
        #1 chk("fetch.idle", imemresp_data, 32'h0);
        imemreq_val  = 1;
        imemreq_addr = 32'h4;
        #1 chk("fetch.4", imemresp_data, 32'hDEADBEEF);
        tick();
        chk("fetch.flags", {30'h0, err_misaligned, err_oob}, 32'h0);
        idle();

        // Store then load, old value visible in the store cycle
        dreq(0, 32'h40, 0);
        #1 chk("ld.old", dmemresp_rdata, 32'hC0DE0010);
        tick();
        dreq(1, 32'h40, 32'h12345678);
        imemreq_val  = 1;
        imemreq_addr = 32'h40;
        #1 chk("st.fetch_old", imemresp_data, 32'hC0DE0010);
        chk("st.rdata0", dmemresp_rdata, 32'h0);
        tick();
        imemreq_val = 0;
        dreq(0, 32'h40, 0);
        #1 chk("ld.new", dmemresp_rdata, 32'h12345678);
        tick();
        chk("ld.nst", 32'(num_stores), 32'd1);
        chk("ld.nld", 32'(num_loads), 32'd2);
        idle();

        // Vector table: MMIO, error capture, reset mid-stream
        for (int i = 0; i < 16; i++) begin
            idle();
            rst = tbl[i].r;
            dmemreq_val   = tbl[i].v;
            dmemreq_type  = tbl[i].t;
            dmemreq_addr  = tbl[i].a;
            dmemreq_wdata = tbl[i].w;
            #1 chk($sformatf("v%0d.rdata", i), dmemresp_rdata, tbl[i].rd);
            tick();
            chk($sformatf("v%0d.mis", i), 32'(err_misaligned), 32'(tbl[i].mis));
            chk($sformatf("v%0d.oob", i), 32'(err_oob), 32'(tbl[i].oob));
            chk($sformatf("v%0d.eaddr", i), err_addr, tbl[i].ea);
            chk($sformatf("v%0d.nl", i), 32'(num_loads), 32'(tbl[i].nl));
            chk($sformatf("v%0d.ns", i), 32'(num_stores), 32'(tbl[i].ns));
            chk($sformatf("v%0d.out2", i), out2, tbl[i].o2);
        end
        idle();
        rst = 1;

        // Preload and store collide on one word: preload wins
        load_val  = 1;
        load_addr = 32'h10;
        load_data = 32'h1;
        dreq(1, 32'h10, 32'h2);
        tick();
        chk("coll.ns", 32'(num_stores), 32'd0);
        chk("coll.flags", {30'h0, err_misaligned, err_oob}, 32'h3);
        idle();
        dreq(0, 32'h10, 0);
        #1 chk("coll.word", dmemresp_rdata, 32'h1);
        tick();
        dreq(1, 32'h2000, 32'h55);
        tick();
        chk("out0.set", out0, 32'h55);
        rst = 0;
        dreq(1, 32'h2000, 32'h66);
        tick();
        chk("rstst.out0", out0, 32'h0);
        chk("rstst.flags", {30'h0, err_misaligned, err_oob}, 32'h0);
        chk("rstst.eaddr", err_addr, 32'h0);
        chk("rstst.cnt", {num_loads, num_stores}, 32'h0);
        rst = 1;
        dreq(0, 32'h10, 0);
        #1 chk("rstst.word", dmemresp_rdata, 32'h1);
        tick();
        idle();

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            rst           = ($urandom_range(0, 39) != 0);
            imemreq_val   = $urandom_range(0, 1);
            imemreq_addr  = rnd_addr();
            dmemreq_val   = ($urandom_range(0, 3) != 0);
            dmemreq_type  = $urandom_range(0, 1);
            dmemreq_addr  = rnd_addr();
            dmemreq_wdata = $urandom;
            load_val      = ($urandom_range(0, 5) == 0);
            load_addr     = $urandom_range(0, 1) ? dmemreq_addr
                                                 : rnd_addr();
            load_data     = $urandom;
            in0           = $urandom;
            in1           = $urandom;
            in2           = $urandom;
            #1;
            chk($sformatf("r%0d.imem", c), imemresp_data, exp_fetch());
            chk($sformatf("r%0d.dmem", c), dmemresp_rdata, exp_load());
            tick();
            chk_regs($sformatf("r%0d", c));
        end
        idle();

        // Saturation of the load counter
        rst = 0;
        tick();
        rst = 1;
        dreq(0, 32'h0, 0);
        repeat (65534) tick();
        chk("sat.fffe", 32'(num_loads), 32'hFFFE);
        repeat (6) tick();
        chk("sat.ffff", 32'(num_loads), 32'hFFFF);
        chk("sat.ns", 32'(num_stores), 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_mem_responder.md
# proc_mem_responder

Synthesizable memory responder for the single-cycle TinyRV1 processor: the target side of the processor's imem/dmem request interface. Serves combinational instruction fetches and data loads from an internal word RAM, commits stores on the clock edge, maps the processor's in/out ports into a small MMIO window, and records protocol errors and access statistics. It replaces the behavioural test memory in FPGA builds and sits between the processor core and the board I/O.

## Interface
- `NUM_WORDS`, 256: RAM depth in 32-bit words; a power of two, at most 2048.
- `MMIO_BASE`, 32'h0000_2000: base byte address of the MMIO window.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `imemreq_val` in 1: instruction fetch valid.
- `imemreq_addr` in 32: fetch byte address.
- `imemresp_data` out 32: fetched word, combinational.
- `dmemreq_val` in 1: data request valid.
- `dmemreq_type` in 1: 0 = load, 1 = store.
- `dmemreq_addr` in 32: data byte address.
- `dmemreq_wdata` in 32: store data.
- `dmemresp_rdata` out 32: load data, combinational.
- `load_val`, `load_addr[31:0]`, `load_data[31:0]` in: preload write port, used while the core is held in reset.
- `in0`, `in1`, `in2` in 32 each: board inputs.
- `out0`, `out1`, `out2` out 32 each: board output registers.
- `err_misaligned` out 1: sticky flag, an access had `addr[1:0]` != 0.
- `err_oob` out 1: sticky flag, an access hit neither RAM nor a defined MMIO word.
- `err_addr` out 32: address of the first error.
- `num_loads` out 16: count of completed data loads.
- `num_stores` out 16: count of completed data stores.

## Operation
- Address map:
  - RAM occupies byte addresses 0 to `NUM_WORDS*4-1`.
  - MMIO stores go to `MMIO_BASE+0/4/8` (`out0`, `out1`, `out2`).
  - MMIO loads come from `MMIO_BASE+0x10/0x14/0x18` (`in0`, `in1`, `in2`). Loads from `MMIO_BASE+0/4/8` return the current out registers.
- Fetch path:
  - Valid, aligned RAM address: `imemresp_data` = RAM word.
  - Any other address, or `imemreq_val` = 0: output is 0.
  - A valid fetch to a bad or misaligned address raises the matching error flag.
  - Fetches never touch MMIO.
- Load: `dmemresp_rdata` = addressed word. Misaligned or out-of-bounds loads return 0 and set the flag. Output is 0 whenever the request is not a valid load.
- Store: written at the rising edge. Misaligned or out-of-bounds stores are dropped and set the flag. Stores to the `in*` addresses count as out-of-bounds.
- Error check order: misaligned is checked before out-of-bounds, so an access sets only one flag.
- Error address: `err_addr` captures the address of the first error after reset and then holds. If a fetch error and a data error occur in the same cycle, the data address is captured.
- Counters: increment only on successful data accesses, including MMIO. They saturate at 16'hFFFF.
- Preload:
  - `load_val` writes RAM regardless of `rst`. Misaligned or out-of-range preload addresses are ignored silently and set no flags.
  - If preload and a data store target the same word in one cycle, the preload wins and the store is dropped. That store is still not counted and raises no error.
  - If they target different words, both writes commit.

## Timing
- Reads are zero-latency (combinational from address).
- Writes take effect at the next edge. A load from the same address in the store cycle returns the old value; the new value is visible the following cycle.
- While `rst` = 0 at an edge:
  - `out0`–`out2` = 0; `err_misaligned`, `err_oob` = 0; `err_addr` = 0; `num_loads`, `num_stores` = 0.
  - Data stores are dropped.
  - RAM contents are not cleared.
- If reset is asserted in the same cycle as a store, the reset wins: no write and no count.
- The first-error capture flag clears on reset.

## Structure
- Package `proc_mem_pkg`:
  - MMIO offset constants (`MMIO_OUT0`…`MMIO_IN2`).
  - Request-type constants `MEM_LOAD = 0` and `MEM_STORE = 1`.
  - An address-decode enum {`DEC_RAM`, `DEC_MMIO_OUT`, `DEC_MMIO_IN`, `DEC_MISALIGN`, `DEC_OOB`}.
- Sub-module `sat_counter16`: enable, synchronous active-low clear, saturating. Instantiate it twice, once for loads and once for stores.
- Use one shared decode function for the fetch, data, and preload paths.

## Test plan
1. **Preload and fetch.** Hold reset, preload `0x0` = 0x00500093 and `0x4` = 0xDEADBEEF, then release. Required: fetch from `0x4` returns 0xDEADBEEF and both flags stay 0.
2. **Store then load.** Store 0x12345678 to `0x40`, then load `0x40` on the same cycle and the next cycle. Required: the same-cycle load returns the old value, the next-cycle load returns 0x12345678, and `num_stores` = 1, `num_loads` = 2.
3. **MMIO.** Drive `in1` = 0xA5A5A5A5 and load `0x2014`; then store 0x7 to `0x2008`. Required: the load returns 0xA5A5A5A5; `out2` = 0x7 after the edge. Store to `0x2010`: `err_oob` = 1 and `err_addr` = 0x2010.
4. **Errors.** Load `0x42`: returns 0, `err_misaligned` = 1, `err_addr` = 0x42. Then store to `0x8000`: `err_oob` = 1, `err_addr` stays 0x42, and the RAM is unchanged.
5. **Collision and reset.** Same cycle: preload `0x10` = 1 and store `0x10` = 2. Required: the word reads 1 and `num_stores` is unchanged. Then assert reset with a pending store to `0x2000`. Required: `out0` = 0, all flags and counters are 0, and RAM `0x10` still reads 1.
6. **Saturation.** Issue 65540 loads. Required: `num_loads` = 0xFFFF.
